// File: rtl/mbtrain_sb_tx_arbiter.sv
// Round-robin arbiter sharing the sideband TX message path between the MBTRAIN substate FSMs.
// Holds a grant through the sideband busy handshake and reports completion or timeout per transfer.
module mbtrain_sb_tx_arbiter #(
    parameter int N_REQ         = 4,
    parameter int BUSY_WAIT_MAX = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_en,
    input  logic [N_REQ-1:0]   i_req_valid,
    input  logic [4*N_REQ-1:0] i_req_msg,
    input  logic               i_sb_busy,
    output logic [3:0]         o_sb_msg,
    output logic               o_sb_valid,
    output logic [N_REQ-1:0]   o_grant,
    output logic [N_REQ-1:0]   o_busy_negedge_detected,
    output logic               o_timeout
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = (BUSY_WAIT_MAX > 1) ? $clog2(BUSY_WAIT_MAX) : 1;
    localparam logic [N_REQ-1:0] ONE_HOT_0 = {{(N_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_DONE
    } state_t;

    state_t             state_reg, state_next;
    logic [IW-1:0]      ptr_reg, ptr_next;
    logic [IW-1:0]      sel_reg, sel_next;
    logic [3:0]         msg_reg, msg_next;
    logic               valid_reg, valid_next;
    logic [N_REQ-1:0]   grant_reg, grant_next;
    logic [N_REQ-1:0]   done_reg, done_next;
    logic               timeout_reg, timeout_next;
    logic [CW-1:0]      cnt_reg, cnt_next;
    logic               busy_d_reg;
    logic               busy_fall;

    logic [3:0]         req_msg_arr [N_REQ];
    logic               found;
    logic [IW-1:0]      pick;
    logic [IW-1:0]      cand;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_msg_split
            assign req_msg_arr[gi] = i_req_msg[4*gi +: 4];
        end
    endgenerate

    assign busy_fall = busy_d_reg & ~i_sb_busy;

    // Search starts one past the last served requester so the most recent winner goes last.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = IW'((int'(ptr_reg) + i) % N_REQ);
            if (!found && i_req_valid[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        state_next   = state_reg;
        ptr_next     = ptr_reg;
        sel_next     = sel_reg;
        msg_next     = msg_reg;
        valid_next   = valid_reg;
        grant_next   = grant_reg;
        done_next    = '0;
        timeout_next = 1'b0;
        cnt_next     = cnt_reg;

        if (!i_en) begin
            state_next = ST_IDLE;
            valid_next = 1'b0;
            grant_next = '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    valid_next = 1'b0;
                    grant_next = '0;
                    if (found) begin
                        state_next = ST_ISSUE;
                        sel_next   = pick;
                        msg_next   = req_msg_arr[pick];
                        valid_next = 1'b1;
                        grant_next = ONE_HOT_0 << pick;
                        cnt_next   = '0;
                    end
                end
                ST_ISSUE: begin
                    if (!i_req_valid[sel_reg]) begin
                        state_next = ST_IDLE;
                        valid_next = 1'b0;
                        grant_next = '0;
                    end else if (i_sb_busy) begin
                        state_next = ST_WAIT_DONE;
                        valid_next = 1'b0;
                    end else if (cnt_reg == CW'(BUSY_WAIT_MAX - 1)) begin
                        state_next   = ST_IDLE;
                        timeout_next = 1'b1;
                        valid_next   = 1'b0;
                        grant_next   = '0;
                        ptr_next     = sel_reg;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
                ST_WAIT_DONE: begin
                    // The transfer is committed here, so a withdrawn valid is not consulted.
                    if (busy_fall) begin
                        state_next = ST_IDLE;
                        done_next  = grant_reg;
                        grant_next = '0;
                        ptr_next   = sel_reg;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    valid_next = 1'b0;
                    grant_next = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            ptr_reg     <= IW'(N_REQ - 1);
            sel_reg     <= '0;
            msg_reg     <= '0;
            valid_reg   <= 1'b0;
            grant_reg   <= '0;
            done_reg    <= '0;
            timeout_reg <= 1'b0;
            cnt_reg     <= '0;
            busy_d_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            ptr_reg     <= ptr_next;
            sel_reg     <= sel_next;
            msg_reg     <= msg_next;
            valid_reg   <= valid_next;
            grant_reg   <= grant_next;
            done_reg    <= done_next;
            timeout_reg <= timeout_next;
            cnt_reg     <= cnt_next;
            busy_d_reg  <= i_sb_busy;
        end
    end

    assign o_sb_msg                = msg_reg;
    assign o_sb_valid              = valid_reg;
    assign o_grant                 = grant_reg;
    assign o_busy_negedge_detected = done_reg;
    assign o_timeout               = timeout_reg;

endmodule

// File: tb/tb_mbtrain_sb_tx_arbiter.sv
// Self-checking bench for mbtrain_sb_tx_arbiter: vector table, directed corner sequences,
// and randomized traffic compared against a transfer-level reference model.
module tb_mbtrain_sb_tx_arbiter;

    localparam int N  = 4;
    localparam int WM = 16;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           en = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [4*N-1:0] req_msg = '0;
    logic           sb_busy = 1'b0;
    logic [3:0]     sb_msg;
    logic           sb_valid;
    logic [N-1:0]   grant;
    logic [N-1:0]   done;
    logic           timeout;

    int checks = 0;
    int failures = 0;

    mbtrain_sb_tx_arbiter #(.N_REQ(N), .BUSY_WAIT_MAX(WM)) dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .i_en                    (en),
        .i_req_valid             (req_valid),
        .i_req_msg               (req_msg),
        .i_sb_busy               (sb_busy),
        .o_sb_msg                (sb_msg),
        .o_sb_valid              (sb_valid),
        .o_grant                 (grant),
        .o_busy_negedge_detected (done),
        .o_timeout               (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         en;
        logic [N-1:0] v;
        logic [15:0]  m;
        logic         busy;
        logic [N-1:0] g;
        logic         sv;
        logic [3:0]   sm;
        logic [N-1:0] d;
        logic         to;
    } vec_t;

    vec_t tbl [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en = 1'b0;
        req_valid = '0;
        req_msg = '0;
        sb_busy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Reference model state: who owns the path and what phase the transfer is in.
    int         m_owner;
    int         m_phase;   // 0 none, 1 offered to sideband, 2 sideband busy
    int         m_waited;
    int         m_last;
    bit         m_prev_busy;
    logic [3:0] m_msg;
    logic [N-1:0] e_done;
    bit         e_to;

    task automatic model_reset();
        m_owner = -1;
        m_phase = 0;
        m_waited = 0;
        m_last = N - 1;
        m_prev_busy = 0;
        m_msg = '0;
        e_done = '0;
        e_to = 0;
    endtask

    task automatic model_step();
        logic [15:0] mv;
        bit fell;
        mv = req_msg;
        fell = m_prev_busy && !sb_busy;
        e_done = '0;
        e_to = 0;
        if (!en) begin
            m_owner = -1;
            m_phase = 0;
        end else if (m_phase == 0) begin
            for (int i = 1; i <= N; i++) begin
                int k;
                k = (m_last + i) % N;
                if (m_phase == 0 && req_valid[k]) begin
                    m_owner = k;
                    m_phase = 1;
                    m_waited = 0;
                    m_msg = mv[4*k +: 4];
                end
            end
        end else if (m_phase == 1) begin
            if (!req_valid[m_owner]) begin
                m_owner = -1;
                m_phase = 0;
            end else if (sb_busy) begin
                m_phase = 2;
            end else if (m_waited == WM - 1) begin
                e_to = 1;
                m_last = m_owner;
                m_owner = -1;
                m_phase = 0;
            end else begin
                m_waited++;
            end
        end else if (fell) begin
            e_done[m_owner] = 1'b1;
            m_last = m_owner;
            m_owner = -1;
            m_phase = 0;
        end
        m_prev_busy = sb_busy;
    endtask

    initial begin
        logic [N-1:0] e_grant;

        // Single request, withdrawal, code 0 forwarding, enable drop
        tbl[0]  = '{1'b1, 4'b0010, 16'h0010, 1'b0, 4'b0010, 1'b1, 4'h1, 4'b0000, 1'b0};
        tbl[1]  = '{1'b1, 4'b0010, 16'h0010, 1'b0, 4'b0010, 1'b1, 4'h1, 4'b0000, 1'b0};
        tbl[2]  = '{1'b1, 4'b0010, 16'h0010, 1'b0, 4'b0010, 1'b1, 4'h1, 4'b0000, 1'b0};
        tbl[3]  = '{1'b1, 4'b0010, 16'h0010, 1'b1, 4'b0010, 1'b0, 4'h0, 4'b0000, 1'b0};
        tbl[4]  = '{1'b1, 4'b0010, 16'h0010, 1'b1, 4'b0010, 1'b0, 4'h0, 4'b0000, 1'b0};
        tbl[5]  = '{1'b1, 4'b0010, 16'h0010, 1'b0, 4'b0000, 1'b0, 4'h0, 4'b0010, 1'b0};
        tbl[6]  = '{1'b1, 4'b0000, 16'h0010, 1'b0, 4'b0000, 1'b0, 4'h0, 4'b0000, 1'b0};
        tbl[7]  = '{1'b1, 4'b0100, 16'h0B00, 1'b0, 4'b0100, 1'b1, 4'hB, 4'b0000, 1'b0};
        tbl[8]  = '{1'b1, 4'b0000, 16'h0B00, 1'b0, 4'b0000, 1'b0, 4'h0, 4'b0000, 1'b0};
        tbl[9]  = '{1'b1, 4'b1001, 16'h7000, 1'b0, 4'b1000, 1'b1, 4'h7, 4'b0000, 1'b0};
        tbl[10] = '{1'b1, 4'b1001, 16'h7000, 1'b1, 4'b1000, 1'b0, 4'h0, 4'b0000, 1'b0};
        tbl[11] = '{1'b1, 4'b1001, 16'h7000, 1'b0, 4'b0000, 1'b0, 4'h0, 4'b1000, 1'b0};
        tbl[12] = '{1'b1, 4'b1001, 16'h7000, 1'b0, 4'b0001, 1'b1, 4'h0, 4'b0000, 1'b0};
        tbl[13] = '{1'b0, 4'b1001, 16'h7000, 1'b0, 4'b0000, 1'b0, 4'h0, 4'b0000, 1'b0};
        tbl[14] = '{1'b1, 4'b0000, 16'h7000, 1'b0, 4'b0000, 1'b0, 4'h0, 4'b0000, 1'b0};

        do_reset();
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_valid", 32'(sb_valid), 32'h0);
        chk("rst_msg", 32'(sb_msg), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_timeout", 32'(timeout), 32'h0);

        for (int i = 0; i < 15; i++) begin
            en = tbl[i].en;
            req_valid = tbl[i].v;
            req_msg = tbl[i].m;
            sb_busy = tbl[i].busy;
            tick();
            $display("vec %0d: grant=%b valid=%b msg=%h done=%b to=%b", i, grant, sb_valid, sb_msg, done, timeout);
            chk($sformatf("vec%0d_grant", i), 32'(grant), 32'(tbl[i].g));
            chk($sformatf("vec%0d_valid", i), 32'(sb_valid), 32'(tbl[i].sv));
            chk($sformatf("vec%0d_done", i), 32'(done), 32'(tbl[i].d));
            chk($sformatf("vec%0d_to", i), 32'(timeout), 32'(tbl[i].to));
            if (tbl[i].sv)
                chk($sformatf("vec%0d_msg", i), 32'(sb_msg), 32'(tbl[i].sm));
        end

        // Round-robin with all requesters valid and 2-cycle busy handshakes
        do_reset();
        en = 1'b1;
        req_valid = 4'b1111;
        req_msg = 16'h4321;
        for (int t = 0; t < 5; t++) begin
            int exp_k;
            exp_k = t % N;
            for (int w = 0; w < 8 && grant == '0; w++) tick();
            $display("rr turn %0d: grant=%b msg=%h", t, grant, sb_msg);
            chk("rr_grant", 32'(grant), 32'(1) << exp_k);
            chk("rr_msg", 32'(sb_msg), 32'(exp_k + 1));
            sb_busy = 1'b1;
            tick();
            tick();
            sb_busy = 1'b0;
            tick();
            chk("rr_done", 32'(done), 32'(1) << exp_k);
            chk("rr_grant_clr", 32'(grant), 32'h0);
            tick();
            chk("rr_done_1cyc", 32'(done), 32'h0);
        end

        // Timeout with busy never rising
        do_reset();
        en = 1'b1;
        req_valid = 4'b0011;
        req_msg = 16'h0021;
        tick();
        chk("to_grant0", 32'(grant), 32'h1);
        for (int i = 1; i < WM; i++) begin
            tick();
            chk("to_early", 32'(timeout), 32'h0);
        end
        tick();
        $display("timeout: to=%b grant=%b valid=%b", timeout, grant, sb_valid);
        chk("to_pulse", 32'(timeout), 32'h1);
        chk("to_grant_clr", 32'(grant), 32'h0);
        chk("to_valid_clr", 32'(sb_valid), 32'h0);
        tick();
        chk("to_1cyc", 32'(timeout), 32'h0);
        chk("to_next_req1", 32'(grant), 32'h2);

        // Message freeze, then enable drop while waiting for busy to fall
        do_reset();
        en = 1'b1;
        req_valid = 4'b0001;
        req_msg = 16'h0001;
        tick();
        chk("frz_grant", 32'(grant), 32'h1);
        chk("frz_msg0", 32'(sb_msg), 32'h1);
        req_msg = 16'h0003;
        tick();
        chk("frz_msg1", 32'(sb_msg), 32'h1);
        chk("frz_valid", 32'(sb_valid), 32'h1);
        sb_busy = 1'b1;
        tick();
        chk("frz_wait_valid", 32'(sb_valid), 32'h0);
        chk("frz_wait_grant", 32'(grant), 32'h1);
        en = 1'b0;
        tick();
        chk("en_drop_grant", 32'(grant), 32'h0);
        en = 1'b1;
        req_valid = '0;
        sb_busy = 1'b0;
        tick();
        chk("en_drop_nopulse", 32'(done), 32'h0);
        tick();
        chk("en_drop_nopulse2", 32'(done), 32'h0);
        $display("freeze/en-drop: grant=%b done=%b", grant, done);

        // Asynchronous reset in WAIT_DONE
        do_reset();
        en = 1'b1;
        req_valid = 4'b0100;
        req_msg = 16'h0500;
        tick();
        chk("ar_grant", 32'(grant), 32'h4);
        chk("ar_msg", 32'(sb_msg), 32'h5);
        sb_busy = 1'b1;
        tick();
        #1;
        rst_n = 1'b0;
        #1;
        chk("ar_grant0", 32'(grant), 32'h0);
        chk("ar_valid0", 32'(sb_valid), 32'h0);
        chk("ar_msg0", 32'(sb_msg), 32'h0);
        chk("ar_done0", 32'(done), 32'h0);
        rst_n = 1'b1;
        sb_busy = 1'b0;
        req_valid = 4'b1111;
        tick();
        chk("ar_first_req0", 32'(grant), 32'h1);
        $display("async reset: first grant after reset=%b", grant);

        // Randomized traffic against the reference model
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            en = ($urandom_range(0, 31) != 0);
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, 7) == 0) req_valid[b] = ~req_valid[b];
            if ($urandom_range(0, 3) == 0) sb_busy = ~sb_busy;
            if ($urandom_range(0, 3) == 0) req_msg = 16'($urandom);
            model_step();
            e_grant = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
            tick();
            chk("rnd_grant", 32'(grant), 32'(e_grant));
            chk("rnd_valid", 32'(sb_valid), 32'(m_phase == 1));
            chk("rnd_done", 32'(done), 32'(e_done));
            chk("rnd_to", 32'(timeout), 32'(e_to));
            if (m_phase == 1) chk("rnd_msg", 32'(sb_msg), 32'(m_msg));
        end
        $display("random: 3000 cycles applied");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mbtrain_sb_tx_arbiter.md
Name: mbtrain_sb_tx_arbiter

Overview:
- Shares the single sideband TX message path between the MBTRAIN substate transmit/receive FSMs (linkspeed, repair, valvref, datavref, ...).
- Each requester presents a 4-bit sideband message code plus a valid flag. The arbiter grants one requester at a time in round-robin order and forwards its message to the sideband encoder.
- It holds the grant until the sideband busy handshake completes, then returns a per-requester busy-negedge pulse.
- It sits between the MBTRAIN substate blocks and the sideband TX wrapper.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- BUSY_WAIT_MAX, 16, cycles to wait for i_sb_busy to rise after issue before abandoning the transfer.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active low
- i_en  in  1  MBTRAIN arbitration enable; low forces IDLE
- i_req_valid  in  N_REQ  per-requester message valid (level)
- i_req_msg  in  4*N_REQ  per-requester message code; requester k uses bits [4k+3:4k]
- i_sb_busy  in  1  sideband TX busy (high while a message is serialised)
- o_sb_msg  out  4  message forwarded to the sideband
- o_sb_valid  out  1  message valid to the sideband
- o_grant  out  N_REQ  one-hot current grant; zero when nothing is granted
- o_busy_negedge_detected  out  N_REQ  one-cycle pulse to the granted requester when its transfer completes
- o_timeout  out  1  one-cycle pulse when BUSY_WAIT_MAX expires

Behaviour:
- Reset: all outputs 0; state IDLE; round-robin pointer = N_REQ-1 (first search starts at requester 0); busy_d = 0; timeout counter 0.
- busy_d is a registered copy of i_sb_busy. busy_fall = busy_d & ~i_sb_busy.
- States: IDLE, ISSUE, WAIT_DONE.
- IDLE:
  - If i_en and any i_req_valid: search from pointer+1 upward with wrap and select the first valid requester k.
  - Next edge: state ISSUE; o_grant = 1<<k; o_sb_msg = latched i_req_msg[k]; o_sb_valid = 1; counter cleared.
  - Latency from request to o_sb_valid is 1 cycle.
- ISSUE (evaluated in priority order):
  - If ~i_en: go to IDLE.
  - Else if ~i_req_valid[k] (requester withdrew): o_sb_valid, o_grant -> 0; IDLE; no done pulse; pointer unchanged.
  - Else if i_sb_busy: o_sb_valid -> 0; WAIT_DONE.
  - Else if counter == BUSY_WAIT_MAX-1: o_timeout pulse; o_sb_valid, o_grant -> 0; pointer <= k; IDLE.
  - Else: increment counter.
  - o_sb_msg stays frozen at the latched value; changes on i_req_msg during a grant are ignored.
- WAIT_DONE:
  - On busy_fall: o_busy_negedge_detected[k] pulses for 1 cycle; o_grant -> 0; pointer <= k; IDLE.
  - Deassertion of i_req_valid[k] here is ignored: the transfer is already committed.
  - If ~i_en: go to IDLE with no pulse.
- No back-to-back grant: at least one IDLE cycle separates transfers. A requester that is still valid after its done pulse re-arbitrates behind the others.
- Simultaneous requests are resolved purely by the rotating pointer. Starvation bound is N_REQ transfers.
- i_en low, in any state: synchronous return to IDLE next cycle; o_sb_valid, o_grant, and pulses cleared; pointer preserved.
- rst_n asserted mid-transfer: immediate asynchronous return to reset values.
- busy_fall seen while in IDLE or ISSUE is ignored.
- Message code 4'b0000 with valid high is forwarded like any other code.

Test Plan:
- Single request: req_valid=4'b0010, msg1=4'h1. o_sb_valid=1, o_sb_msg=4'h1, o_grant=4'b0010 at cycle+1. Raise busy 3 cycles later: o_sb_valid=0. Drop busy: o_busy_negedge_detected=4'b0010 for exactly 1 cycle, grant=0.
- Round-robin: all four valid continuously, each busy handshake 2 cycles. Grant order is 0,1,2,3,0; each requester receives exactly one done pulse per turn.
- Withdrawal: grant req2 (msg 4'hB), drop req_valid[2] before busy rises. o_sb_valid=0 next cycle, no done pulse. Next grant goes to req3 if valid, otherwise wraps.
- Timeout: grant req0, busy held low. o_timeout pulses at issue+BUSY_WAIT_MAX cycles (16), grant clears, next grant skips to req1.
- Message freeze and enable drop: change msg0 from 4'h1 to 4'h3 during ISSUE; o_sb_msg stays 4'h1. Drop i_en in WAIT_DONE: IDLE next cycle, no pulse on later busy fall.
- Async reset mid-WAIT_DONE: all outputs 0 immediately. First grant after reset goes to req0.
